// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX queue arbiter.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } uart_arb_state_t;

  localparam int UART_DATA_WIDTH  = 8;
  localparam int UART_ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating priority encoder: first set request at or above rr_ptr_i, wrapping.
module uart_rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
  output logic [$clog2(N_REQ)-1:0] winner_o,
  output logic                     any_o
);

  localparam int GW = $clog2(N_REQ);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int             idx;
    logic [GW-1:0]  sel;
    idx      = 0;
    sel      = '0;
    winner_o = '0;
    any_o    = |req_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = idx[GW-1:0];
      if (req_i[sel]) winner_o = sel;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding the UART TX queue from N_REQ byte producers.
// Define UART_TX_ARB_PACKET_LOCK_EN to hold the grant until the req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        tx_queue_full,
  output logic                        tx_queue_we,
  output logic [DATA_WIDTH-1:0]       tx_queue_din,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);

  localparam int GW = $clog2(N_REQ);

  uart_arb_state_t state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   winner;
  logic            any_req;
  logic            xfer;
  logic            end_grant;

  uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign xfer = (state_q == ARB_GRANT) && req_valid[grant_q] && !tx_queue_full;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  assign end_grant = xfer && req_last[grant_q];
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign end_grant   = xfer;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (end_grant) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Ready depends only on ownership and queue space, never on req_data.
  always_comb begin
    req_ready    = '0;
    tx_queue_we  = 1'b0;
    tx_queue_din = '0;
    busy         = (state_q == ARB_GRANT);
    if (state_q == ARB_GRANT) req_ready[grant_q] = !tx_queue_full;
    if (xfer) begin
      tx_queue_we  = 1'b1;
      tx_queue_din = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed cycle-table bench for uart_tx_arbiter (N_REQ=2, 8-bit data).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_queue_full;
  logic        tx_queue_we;
  logic [7:0]  tx_queue_din;
  logic [0:0]  grant_id;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic       full;
    logic [1:0] rdy;
    logic       we;
    logic [7:0] din;
    logic       busy;
    logic       gid;
  } vec_t;

  vec_t tbl[$];

  uart_tx_arbiter #(.N_REQ(2), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_queue_full (tx_queue_full),
    .tx_queue_we   (tx_queue_we),
    .tx_queue_din  (tx_queue_din),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] last, logic full, logic [1:0] rdy,
                              logic we, logic [7:0] din, logic bsy, logic gid);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.last = last; r.full = full;
    r.rdy = rdy; r.we = we; r.din = din; r.busy = bsy; r.gid = gid;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] last, input logic full);
    req_valid     = v;
    req_data      = {d1, d0};
    req_last      = last;
    tx_queue_full = full;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);

`ifdef UART_TX_ARB_PACKET_LOCK_EN
    tbl.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b01, 1, 8'h41, 1, 0));
    tbl.push_back(mk(2'b01, 8'h42, 8'h00, 2'b00, 0, 2'b01, 1, 8'h42, 1, 0));
    tbl.push_back(mk(2'b01, 8'h43, 8'h00, 2'b01, 0, 2'b01, 1, 8'h43, 1, 0));
    tbl.push_back(mk(2'b11, 8'h50, 8'h60, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b11, 8'h50, 8'h60, 2'b00, 0, 2'b10, 1, 8'h60, 1, 1));
    tbl.push_back(mk(2'b11, 8'h50, 8'h61, 2'b10, 0, 2'b10, 1, 8'h61, 1, 1));
    tbl.push_back(mk(2'b01, 8'h55, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(2'b01, 8'h55, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 1, 0));
    tbl.push_back(mk(2'b01, 8'h55, 8'h00, 2'b00, 0, 2'b01, 1, 8'h55, 1, 0));
    tbl.push_back(mk(2'b01, 8'h56, 8'h00, 2'b01, 0, 2'b01, 1, 8'h56, 1, 0));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
`else
    tbl.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b01, 1, 8'h41, 1, 0));
    tbl.push_back(mk(2'b01, 8'h42, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b01, 8'h42, 8'h00, 2'b00, 0, 2'b01, 1, 8'h42, 1, 0));
    tbl.push_back(mk(2'b11, 8'h43, 8'h61, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b11, 8'h43, 8'h61, 2'b00, 0, 2'b10, 1, 8'h61, 1, 1));
    tbl.push_back(mk(2'b11, 8'h43, 8'h62, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b11, 8'h43, 8'h62, 2'b00, 0, 2'b01, 1, 8'h43, 1, 0));
    tbl.push_back(mk(2'b10, 8'h00, 8'h62, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(2'b10, 8'h00, 8'h62, 2'b00, 1, 2'b00, 0, 8'h00, 1, 1));
    tbl.push_back(mk(2'b10, 8'h00, 8'h62, 2'b00, 0, 2'b10, 1, 8'h62, 1, 1));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b01, 8'h44, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b00, 8'h44, 8'h00, 2'b00, 0, 2'b01, 0, 8'h00, 1, 0));
    tbl.push_back(mk(2'b10, 8'h44, 8'h63, 2'b00, 0, 2'b01, 0, 8'h00, 1, 0));
    tbl.push_back(mk(2'b11, 8'h44, 8'h63, 2'b00, 0, 2'b01, 1, 8'h44, 1, 0));
    tbl.push_back(mk(2'b10, 8'h00, 8'h63, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b10, 8'h00, 8'h63, 2'b00, 0, 2'b10, 1, 8'h63, 1, 1));
`endif

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_we", int'(tx_queue_we), 0);
    check("rst_din", int'(tx_queue_din), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_gid", int'(grant_id), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].last, tbl[i].full);
      #1;
      check($sformatf("c%0d_ready", i), int'(req_ready), int'(tbl[i].rdy));
      check($sformatf("c%0d_we", i), int'(tx_queue_we), int'(tbl[i].we));
      check($sformatf("c%0d_din", i), int'(tx_queue_din), int'(tbl[i].din));
      check($sformatf("c%0d_busy", i), int'(busy), int'(tbl[i].busy));
      if (tbl[i].busy) check($sformatf("c%0d_gid", i), int'(grant_id), int'(tbl[i].gid));
    end

    // Async reset between clock edges while req1 owns the queue.
    @(negedge clk);
    drive(2'b10, 8'h00, 8'h70, 2'b00, 1'b0);
    #1;
    check("ar_idle_busy", int'(busy), 0);
    @(negedge clk);
    #1;
    check("ar_grant_busy", int'(busy), 1);
    check("ar_grant_gid", int'(grant_id), 1);
    check("ar_grant_din", int'(tx_queue_din), 8'h70);
    #1;
    reset = 1'b1;
    #1;
    check("ar_busy", int'(busy), 0);
    check("ar_we", int'(tx_queue_we), 0);
    check("ar_ready", int'(req_ready), 0);
    check("ar_din", int'(tx_queue_din), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 8'h80, 8'h71, 2'b00, 1'b0);
    #1;
    check("ar_after_busy", int'(busy), 0);
    @(negedge clk);
    #1;
    check("ar_restart_gid", int'(grant_id), 0);
    check("ar_restart_ready", int'(req_ready), 1);
    check("ar_restart_din", int'(tx_queue_din), 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit queue between `N_REQ` byte producers (CPU store path, debug monitor, DMA). Round-robin grant with per-packet locking; the winner's bytes go into the TX queue, which the UART TX controller drains onto the line. Sits between the bus-side producers and the TX queue write port.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..8.
- `DATA_WIDTH`, default 8: byte width written to the TX queue.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a byte on `req_data[i]`.
- `req_data`  in  N_REQ*DATA_WIDTH  packed bytes; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  N_REQ  byte on requester i is the last of its packet.
- `req_ready`  out  N_REQ  byte of requester i accepted this cycle when valid&ready.
- `tx_queue_full`  in  1  TX queue cannot accept a write.
- `tx_queue_we`  out  1  TX queue write strobe.
- `tx_queue_din`  out  DATA_WIDTH  byte written to TX queue.
- `grant_id`  out  $clog2(N_REQ)  index of current owner; valid while `busy`.
- `busy`  out  1  a requester holds the queue.

## Operation
- States: ARB_IDLE, ARB_GRANT.
- ARB_IDLE: if any `req_valid`, select winner = first set bit scanning from `rr_ptr` upward, wrapping modulo N_REQ; register it into `grant_id`, go ARB_GRANT. No bytes accepted in ARB_IDLE. No valid -> stay.
- ARB_GRANT: `req_ready[grant_id] = !tx_queue_full`; all other ready bits 0. Transfer = `req_valid[grant_id] & req_ready[grant_id]`; on transfer `tx_queue_we=1`, `tx_queue_din=req_data[grant_id]`.
- Transfer with `req_last[grant_id]=1` -> ARB_IDLE, `rr_ptr <= grant_id+1` (wraps N_REQ-1 -> 0).
- Owner deasserting `req_valid` mid-packet: grant held, no write, no timeout.
- `tx_queue_full` in ARB_GRANT: ready 0, no write, state held; resumes the cycle full drops.
- Requests from non-owners are ignored until the owner's packet ends; they are served in rotation order afterwards.
- `tx_queue_din` = 0 whenever `tx_queue_we` = 0.

## Timing
- Reset (async, immediate): state ARB_IDLE, `rr_ptr`=0, `grant_id`=0, `busy`=0, `req_ready`=0, `tx_queue_we`=0, `tx_queue_din`=0.
- Reset mid-packet: packet abandoned; bytes already written stay in queue; requester restarts.
- Arbitration latency: valid seen in cycle n -> `busy`=1 and first write possible in cycle n+1.
- In-packet throughput: one byte per cycle while queue not full.
- Packet gap: last byte at cycle m -> ARB_IDLE at m+1 -> next grant at m+2 (one dead cycle).
- `req_ready`, `tx_queue_we`, `tx_queue_din` are combinational from state, `grant_id`, `req_valid`, `tx_queue_full`; no combinational path from `req_data` to `req_ready`.
- Requesters must hold valid/data/last stable until accepted.

## Configuration
- `UART_TX_ARB_PACKET_LOCK_EN` defined: behaviour as above, grant held until `req_last` byte.
- Undefined: `req_last` ignored; every transfer ends the grant (ARB_GRANT -> ARB_IDLE, `rr_ptr` advances), i.e. per-byte round-robin, max one byte per 2 cycles.

## Structure
- `uart_pkg`: `uart_arb_state_t` enum (ARB_IDLE, ARB_GRANT), `UART_DATA_WIDTH` constant = 8, `UART_ARB_MAX_REQ` = 8.
- Sub-module `uart_rr_picker`: combinational rotating priority encoder (inputs request vector, `rr_ptr`; outputs winner index, any-request flag).
- Top holds FSM, `rr_ptr`, `grant_id` registers and the output muxing.

## Test plan
- Reset then req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), queue not full -> 3 consecutive `tx_queue_we`, din 0x41/0x42/0x43, `grant_id`=0, `busy` falls the cycle after 0x43.
- req0 and req1 both valid same cycle after reset -> req0 served first, then req1 after one dead cycle; repeat -> req1 first (rr_ptr=1... rotation confirmed by alternation).
- Owner req1 mid-packet, req0 raises valid -> req0 `req_ready` stays 0 until req1's last byte; no byte of req0 interleaved.
- `tx_queue_full`=1 for 4 cycles during packet -> no writes, `req_ready`=0, grant held; byte 0x55 written the cycle full drops.
- Assert `reset` asynchronously mid-packet (between clock edges) -> `busy`, `tx_queue_we`, `req_ready` go 0 immediately; next arbitration starts at req0.
- Macro undefined, req0 and req1 each stream 2-byte packets -> written order req0 b0, req1 b0, req0 b1, req1 b1, each write separated by one idle cycle.
